sync_mod_counter: RTL
=====================

// Module: sync_mod_counter
//
// PURPOSE
// - Parametrised synchronous modulo-N counter: synchronous clear, parallel load and dual count enables (enp/ent).
// - Ripple-carry output for cascading.
// - Generalises the fixed 4-bit decade counter next-state logic to arbitrary width and modulus.
// - Adds a registered wrap pulse and an optional down-count mode.
// - Used as a prescaler / event-count stage in the SAGA benchmark control datapaths; instances cascade via rco -> ent.
//
// PARAMETERS
// WIDTH    4   counter/data width in bits; legal range 2..16
// MODULUS  10  count sequence 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH (elaboration error otherwise)
//
// PORTS
// clk      in   1      rising-edge clock
// rst_n    in   1      asynchronous active-low reset
// clr_n    in   1      synchronous clear, active low (highest synchronous priority)
// load_n   in   1      synchronous parallel load, active low
// enp      in   1      count enable P (does not gate rco)
// ent      in   1      count enable T (gates rco; cascade input)
// d        in   WIDTH  parallel load data
// q        out  WIDTH  registered count value
// rco      out  1      ripple carry out, combinational: ent & (q == terminal value)
// wrap     out  1      registered one-cycle pulse, high the cycle after q wrapped by counting
// up_dn    in   1      only with COUNT_DOWN_EN: 1 = up, 0 = down
//
// BEHAVIOUR
// Reset
// - rst_n low: q = 0 and wrap = 0 immediately, independent of clk.
// - Deassertion is synchronised externally.
// - rco follows the combinational equation at all times (0 while ent = 0).
//
// Synchronous priority, evaluated each rising clk edge
// - clr_n = 0: q <= 0, wrap <= 0.
// - else load_n = 0: q <= d, wrap <= 0. Enables are ignored.
// - else enp & ent:
//   - q == MODULUS-1 (terminal): q <= 0, wrap <= 1.
//   - q > MODULUS-1 (out-of-range load): q <= 0, wrap <= 0.
//   - otherwise: q <= q + 1, wrap <= 0.
// - else hold q; wrap <= 0.
//
// Datapath and timing
// - Arithmetic is WIDTH bits; no carry out of the adder is used.
// - Latency: one clock from enable or load to q. rco has zero latency from q and ent.
// - wrap is high for exactly one cycle per wrap event. It never stays high across two consecutive cycles unless the counter wraps on consecutive cycles (MODULUS = 2 with continuous enable: wrap toggles 1,0,1,0...).
// - Cascading: stage k ent = rco of stage k-1; all stages share enp and clk. This gives a synchronous multi-digit counter with no extra logic.
//
// Boundary conditions
// - clr_n and load_n both low: clear wins.
// - Load asserted on the terminal cycle: the load wins and no wrap pulse is produced.
// - rst_n asserted mid-count: state is lost and the count restarts from 0.
// - MODULUS = 2**WIDTH: natural binary rollover; the out-of-range branch is unreachable.
//
// CONFIGURATION
// Macro SYNC_MOD_COUNTER_DOWN_EN
// - Defined:
//   - Port up_dn exists.
//   - up_dn = 0 with enp & ent: q == 0 gives q <= MODULUS-1 and wrap <= 1; q > MODULUS-1 gives q <= MODULUS-1 and wrap <= 0; otherwise q <= q - 1.
//   - Terminal value for rco is 0 when counting down and MODULUS-1 when counting up.
//   - up_dn is sampled at the same edge as the enables.
// - Undefined:
//   - No up_dn port; up-count only.
//   - rco terminal value is MODULUS-1.
//
// TESTING (WIDTH=4, MODULUS=10 unless stated)
// 1. Reset/count: rst_n low then high, enp=ent=1 for 12 cycles -> q = 0,1..9,0,1; wrap high only the cycle q returns to 0; rco=1 while q=9.
// 2. Enable gating: q=9, ent=0, enp=1 -> q holds 9, rco=0. Then ent=1, enp=0 -> q holds 9, rco=1.
// 3. Priority: clr_n=0 with load_n=0, d=5 -> q=0. Then load_n=0, d=9 at q=9 with enables on -> q=9, wrap=0.
// 4. Out-of-range: load d=13, then enable one cycle -> q=0, wrap=0. Async reset mid-count at q=6 -> q=0 immediately.
// 5. Cascade: two instances, stage1 ent = stage0 rco, run 100 cycles -> {q1,q0} reaches 9,9 then 0,0; stage1 wrap pulses once.
// 6. With SYNC_MOD_COUNTER_DOWN_EN, up_dn=0 from q=2, 4 cycles -> q = 1,0,9,8; wrap pulses once; rco=1 at q=0.

Source files
------------

// File: rtl/sync_mod_counter.sv
// Parametrised synchronous modulo-N counter with clear, load, enp/ent enables,
// ripple-carry out and registered wrap pulse. Optional down count: SYNC_MOD_COUNTER_DOWN_EN.
module sync_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] d,
`ifdef SYNC_MOD_COUNTER_DOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_param
    $error("sync_mod_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_up;
  logic [WIDTH-1:0] w_term;

`ifdef SYNC_MOD_COUNTER_DOWN_EN
  assign w_up = up_dn;
`else
  assign w_up = 1'b1;
`endif

  // Terminal value depends on direction; rco is intentionally combinational for cascading.
  assign w_term = w_up ? TERM : '0;
  assign rco    = ent & (r_q == w_term);
  assign q      = r_q;
  assign wrap   = r_wrap;

  // Next-state: clear > load > count > hold.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (!clr_n) begin
      w_q_nxt = '0;
    end else if (!load_n) begin
      w_q_nxt = d;
    end else if (enp && ent) begin
      if (w_up) begin
        if (r_q == TERM) begin
          w_q_nxt    = '0;
          w_wrap_nxt = 1'b1;
        end else if (r_q > TERM) begin
          w_q_nxt = '0;
        end else begin
          w_q_nxt = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_q_nxt    = TERM;
          w_wrap_nxt = 1'b1;
        end else if (r_q > TERM) begin
          w_q_nxt = TERM;
        end else begin
          w_q_nxt = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

endmodule
